// File: rtl/twiddle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_pkg
// Description : Shared types and constants for the twiddle fetch block:
//               controller state encoding, FIFO depth and credit width.
// Revision    : 1.0 - initial release
// ============================================================================
package twiddle_pkg;

    // Depth of the response FIFO that decouples ROM latency from the consumer.
    localparam int FIFO_DEPTH = 4;

    // Credit sums FIFO occupancy plus up to two reads still in flight.
    localparam int CRED_W = $clog2(FIFO_DEPTH + 2 + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tw_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tw_skid_fifo
// Description : Small circular FIFO carrying a data word plus a last flag.
//               The head is presented combinationally; count reports
//               current occupancy for upstream credit accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module tw_skid_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_MAX  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] last_q, last_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count_q != '0);
    assign head_data  = data_q[rd_ptr_q];
    assign head_last  = last_q[rd_ptr_q];
    assign count      = count_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && head_valid;
    assign do_push = push && ((count_q != CNT_FULL) || do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_fetch
// Description : Streams the N/2 twiddle words of one FFT stage from a
//               one-cycle-latency ROM to a butterfly through a ready/valid
//               handshake. ROM reads are credit-limited so the response FIFO
//               can never overflow under backpressure.
//               Optional macro TWIDDLE_CONJ_EN adds a conj input that
//               negates (with saturation) the imaginary half of each word.
// Revision    : 1.0 - initial release
// ============================================================================
module twiddle_fetch
    import twiddle_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [$clog2(ADDR_WIDTH)-1:0] stage,
`ifdef TWIDDLE_CONJ_EN
    input  logic                          conj,
`endif
    output logic                          rom_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_dout,
    output logic [DATA_WIDTH-1:0]         tw_data,
    output logic                          tw_valid,
    input  logic                          tw_ready,
    output logic                          tw_last,
    output logic                          busy,
    output logic                          done
);

    localparam int                    SW     = $clog2(ADDR_WIDTH);
    localparam int                    JW     = ADDR_WIDTH - 1;
    localparam logic [JW-1:0]         J_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] N_HALF = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

    state_t                state_q, state_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [JW-1:0]         j_q, j_d;          // index of the most recent read
    logic                  rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic                  rsp_pend_q, rsp_pend_d;  // rom_dout valid this cycle
    logic                  rsp_last_q, rsp_last_d;
    logic                  done_q, done_d;
`ifdef TWIDDLE_CONJ_EN
    logic                  conj_q, conj_d;
`endif

    logic                  stage_ok;
    logic [JW-1:0]         next_j;
    logic [ADDR_WIDTH-1:0] span_mask;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CRED_W-1:0]     fifo_count;
    logic [CRED_W-1:0]     credit;
    logic                  credit_ok;
    logic                  xfer;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] wr_data;

    assign stage_ok = ({1'b0, stage} < (SW + 1)'(ADDR_WIDTH));
    assign xfer     = tw_valid && tw_ready;

    // Butterfly j of stage s reads (j mod (N >> (s+1))) * 2^s.
    assign next_j    = j_q + 1'b1;
    assign span_mask = (N_HALF >> stage_q) - 1'b1;
    assign next_addr = ({1'b0, next_j} & span_mask) << stage_q;

    // Reads already committed but not yet in the FIFO count against its space.
    assign credit    = fifo_count + CRED_W'(rom_en_q) + CRED_W'(rsp_pend_q);
    assign credit_ok = (credit < CRED_W'(FIFO_DEPTH));

`ifdef TWIDDLE_CONJ_EN
    localparam int            HW       = DATA_WIDTH / 2;
    localparam logic [HW-1:0] IMAG_MIN = {1'b1, {(HW-1){1'b0}}};
    localparam logic [HW-1:0] IMAG_MAX = {1'b0, {(HW-1){1'b1}}};
    logic [HW-1:0] imag_neg;
    // The most negative imaginary value has no positive twin, so it saturates.
    assign imag_neg = (rom_dout[HW-1:0] == IMAG_MIN) ? IMAG_MAX : (~rom_dout[HW-1:0] + 1'b1);
    assign wr_data  = conj_q ? {rom_dout[DATA_WIDTH-1:HW], imag_neg} : rom_dout;
`else
    assign wr_data  = rom_dout;
`endif

    // Controller next-state, read issue and response tracking.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        j_d        = j_q;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        rsp_pend_d = rom_en_q;
        rsp_last_d = rom_en_q && (j_q == J_LAST);
        done_d     = xfer && tw_last;
`ifdef TWIDDLE_CONJ_EN
        conj_d     = conj_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && stage_ok) begin
                    state_d    = ISSUE;
                    stage_d    = stage;
                    j_d        = '0;
                    rom_en_d   = 1'b1;
                    rom_addr_d = '0;
`ifdef TWIDDLE_CONJ_EN
                    conj_d     = conj;
`endif
                end
            end
            ISSUE: begin
                if (rom_en_q && (j_q == J_LAST)) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    rom_en_d   = 1'b1;
                    j_d        = next_j;
                    rom_addr_d = next_addr;
                end
            end
            DRAIN: begin
                if (xfer && tw_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset aborts any stage and drops late ROM data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            j_q        <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rsp_pend_q <= 1'b0;
            rsp_last_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef TWIDDLE_CONJ_EN
            conj_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            j_q        <= j_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_last_q <= rsp_last_d;
            done_q     <= done_d;
`ifdef TWIDDLE_CONJ_EN
            conj_q     <= conj_d;
`endif
        end
    end

    tw_skid_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CRED_W)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (rsp_pend_q),
        .push_data  (wr_data),
        .push_last  (rsp_last_q),
        .pop        (xfer),
        .head_data  (tw_data),
        .head_last  (head_last),
        .head_valid (tw_valid),
        .count      (fifo_count)
    );

    assign tw_last  = head_last && tw_valid;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_fetch
// Description : Self-checking bench for twiddle_fetch (N = 32) with a
//               one-cycle ROM model and a queue-based reference of the
//               expected address/word stream per stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_fetch;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NP = 1 << AW;
    localparam int NW = NP / 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    stage = '0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout = '0;
    logic [DW-1:0] tw_data;
    logic          tw_valid;
    logic          tw_ready = 1'b1;
    logic          tw_last;
    logic          busy;
    logic          done;
`ifdef TWIDDLE_CONJ_EN
    logic          conj = 1'b0;
`endif

    twiddle_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .stage    (stage),
`ifdef TWIDDLE_CONJ_EN
        .conj     (conj),
`endif
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .tw_data  (tw_data),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_last  (tw_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // One-cycle ROM model
    logic [DW-1:0] rom_mem [NP];
    always @(posedge clock) if (rom_en) rom_dout <= rom_mem[rom_addr];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] exp_data[$];
    int            exp_addr[$];
    int            addr_seen[$];
    logic [DW-1:0] got_data[$];
    int            n_issued = 0;
    int            n_xfer   = 0;
    int            first_cyc = 0;
    int            last_cyc  = 0;
    bit            last_prev = 1'b0;
    bit            cur_conj  = 1'b0;

    function automatic logic [DW-1:0] model_word(input int a);
        logic [DW-1:0] w;
        longint        im;
        w = rom_mem[a];
        if (cur_conj) begin
            im = longint'($signed(w[31:0]));
            im = -im;
            if (im > 64'sd2147483647) im = 64'sd2147483647;
            w[31:0] = im[31:0];
        end
        return w;
    endfunction

    task automatic build_exp(input int s);
        int span;
        exp_data.delete(); exp_addr.delete(); addr_seen.delete(); got_data.delete();
        n_issued = 0; n_xfer = 0; first_cyc = 0; last_cyc = 0;
        span = NP >> (s + 1);
        for (int j = 0; j < NW; j++) begin
            exp_addr.push_back((j % span) * (1 << s));
            exp_data.push_back(model_word((j % span) * (1 << s)));
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (reset_n) begin
            if (rom_en) begin
                addr_seen.push_back(int'(rom_addr));
                n_issued++;
                chk("credit", 64'(n_issued - n_xfer <= 4), 64'd1);
            end
            if (tw_valid) begin
                if (n_xfer < exp_data.size()) begin
                    chk("data", tw_data, exp_data[n_xfer]);
                    chk("last", 64'(tw_last), 64'(n_xfer == exp_data.size() - 1));
                end else begin
                    chk("extra_valid", 64'(tw_valid), 64'd0);
                end
                if (tw_ready) begin
                    got_data.push_back(tw_data);
                    n_xfer++;
                    if (n_xfer == 1) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end
            chk("done", 64'(done), 64'(last_prev));
            last_prev = tw_valid && tw_ready && tw_last;
        end else begin
            last_prev = 1'b0;
        end
    end

    // mode 0: ready high, 1: random ready, 2: ready low 6 cycles at word 5
    task automatic run_stage(input int s, input int mode, input bit poke);
        int hold_left;
        bit hold_used;
        bit fin;
        int start_cyc;
        hold_left = 0; hold_used = 1'b0; fin = 1'b0;
        build_exp(s);
        @(posedge clock); #1;
        start = 1'b1; stage = 3'(s); tw_ready = 1'b1;
        @(negedge clock);
        chk("busy_pre", 64'(busy), 64'd0);
        start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("lat_rom_en", 64'(rom_en), 64'd1);
        chk("lat_addr0", 64'(rom_addr), 64'd0);
        chk("busy_run", 64'(busy), 64'd1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("lat_no_valid", 64'(tw_valid), 64'd0);
        for (int k = 0; k < 400 && !fin; k++) begin
            @(posedge clock); #1;
            if (mode == 1) tw_ready = ($urandom_range(0, 3) != 0);
            else if (mode == 2) begin
                if (!hold_used && n_xfer == 5) begin hold_left = 6; hold_used = 1'b1; end
                tw_ready = (hold_left == 0);
                if (hold_left > 0) hold_left--;
            end else tw_ready = 1'b1;
            if (poke && k == 3) begin start = 1'b1; stage = 3'((s + 1) % AW); end
            if (poke && k == 4) start = 1'b0;
            @(negedge clock);
            if (done) fin = 1'b1;
        end
        chk("stage_timeout", 64'(fin), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("words", 64'(n_xfer), 64'(NW));
        chk("reads", 64'(addr_seen.size()), 64'(NW));
        for (int j = 0; j < NW && j < addr_seen.size(); j++)
            chk("addr", 64'(addr_seen[j]), 64'(exp_addr[j]));
        if (mode == 0) begin
            chk("lat_first", 64'(first_cyc), 64'(start_cyc + 3));
            chk("rate", 64'(last_cyc - first_cyc), 64'(NW - 1));
        end
        tw_ready = 1'b1;
    endtask

    task automatic run_reset_mid(input int s);
        build_exp(s);
        @(posedge clock); #1;
        start = 1'b1; stage = 3'(s); tw_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 60 && n_xfer < 7; k++) @(negedge clock);
        chk("reach_word7", 64'(n_xfer >= 7), 64'd1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_rom_en", 64'(rom_en), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_valid", 64'(tw_valid), 64'd0);
        chk("rst_last", 64'(tw_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", tw_data, 64'd0);
        build_exp(s);
        exp_data.delete();
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("post_rst_valid", 64'(tw_valid), 64'd0);
            chk("post_rst_rom_en", 64'(rom_en), 64'd0);
        end
        run_stage(s, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NP; i++) rom_mem[i] = {$urandom, $urandom};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("init_rom_en", 64'(rom_en), 64'd0);
        chk("init_rom_addr", 64'(rom_addr), 64'd0);
        chk("init_valid", 64'(tw_valid), 64'd0);
        chk("init_last", 64'(tw_last), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_done", 64'(done), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Out-of-range stages are ignored
        for (int v = AW; v < 8; v += 2) begin
            @(posedge clock); #1;
            start = 1'b1; stage = 3'(v);
            @(posedge clock); #1;
            start = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clock);
                chk("bad_stage_busy", 64'(busy), 64'd0);
                chk("bad_stage_rom_en", 64'(rom_en), 64'd0);
            end
        end

        run_stage(0, 0, 1'b0);
        run_stage(1, 0, 1'b0);
        run_stage(4, 0, 1'b0);
        run_stage(2, 2, 1'b0);
        run_stage(3, 0, 1'b1);
        for (int r = 0; r < 4; r++) run_stage(int'($urandom_range(0, AW - 1)), 1, r[0]);
        run_reset_mid(1);

`ifdef TWIDDLE_CONJ_EN
        rom_mem[0] = 64'h1234_5678_8000_0000;
        rom_mem[1] = 64'h9ABC_DEF0_0000_0001;
        conj = 1'b1; cur_conj = 1'b1;
        run_stage(0, 0, 1'b0);
        if (got_data.size() >= 2) begin
            chk("conj_min", got_data[0], 64'h1234_5678_7FFF_FFFF);
            chk("conj_one", got_data[1], 64'h9ABC_DEF0_FFFF_FFFF);
        end else begin
            chk("conj_words", 64'(got_data.size()), 64'd2);
        end
        conj = 1'b0; cur_conj = 1'b0;
        run_stage(0, 1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
